// File: rtl/bus_arbiter2_pkg.sv
// Shared definitions for the two-master bus arbiter.
// Holds the default watchdog timeout and burst cap plus the ownership state type.
package bus_arbiter2_pkg;

  // Default cycles a forwarded transfer may wait for the slave before error completion.
  localparam int unsigned BUS_TIMEOUT   = 1023;
  // Default completed transfers before ownership is forcibly released.
  localparam int unsigned BUS_BURST_MAX = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Response watchdog for one outstanding bus transfer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : transfer forwarded this cycle (arms the counter)
//   done     : slave completed the transfer this cycle (disarms)
//   expire   : TIMEOUT cycles have elapsed since start without done
module bus_watchdog
  import bus_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT = BUS_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic done,
  output logic expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic          run_q;
  logic [CW-1:0] cnt_q;

  // cnt_q equals the number of cycles since the strobe cycle, so expiry lands on
  // strobe + TIMEOUT.
  assign expire = run_q && (cnt_q == CW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      cnt_q <= CW'(1);
    end else if (done || expire) begin
      run_q <= 1'b0;
      cnt_q <= '0;
    end else if (run_q) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master bus arbiter merging the instruction- and data-side MMU physical ports
// onto one slave port. Round-robin ownership with a burst cap, combinational
// strobe/completion pass-through and a response watchdog that turns a hung slave
// into an error completion.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   mN_req                 : master N requests ownership
//   mN_gnt / mN_hrd        : master N owns the bus / bus held by the other master
//   mN_a, mN_d             : address / write data, held from strobe until ready
//   mN_we, mN_rd           : one-cycle transfer strobes
//   mN_spo, mN_ready, mN_err : read data, completion pulse, completion was a timeout
//   s_a, s_d, s_we, s_rd   : forwarded transfer to the slave
//   s_spo, s_ready         : slave read data and completion
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int unsigned TIMEOUT   = BUS_TIMEOUT,
  parameter int unsigned BURST_MAX = BUS_BURST_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  output logic        m0_gnt,
  output logic        m0_hrd,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_req,
  output logic        m1_gnt,
  output logic        m1_hrd,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready
);

  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic [BW-1:0] burst_q, burst_d;

  logic        owning;
  logic        owner;
  logic        own_req, own_we, own_rd;
  logic [31:0] own_a, own_d;
  logic        fwd, ok, timeout, completion, burst_hit, release_bus;
  logic        expire;

  // Outputs are forced quiet during reset so an in-flight completion is swallowed.
  assign owning  = (state_q != StIdle) && !rst;
  assign owner   = (state_q == StOwn1);

  assign own_req = owner ? m1_req : m0_req;
  assign own_we  = owner ? m1_we  : m0_we;
  assign own_rd  = owner ? m1_rd  : m0_rd;
  assign own_a   = owner ? m1_a   : m0_a;
  assign own_d   = owner ? m1_d   : m0_d;

  assign fwd        = owning && !busy_q && (own_we || own_rd);
  assign ok         = owning && busy_q && s_ready;
  // A slave response in the expiry cycle still counts as a normal completion.
  assign timeout    = owning && busy_q && expire && !s_ready;
  assign completion = ok || timeout;

  assign s_we = fwd && own_we;
  assign s_rd = fwd && own_rd;
  assign s_a  = owning ? own_a : '0;
  assign s_d  = owning ? own_d : '0;

  assign m0_gnt   = owning && !owner;
  assign m1_gnt   = owning && owner;
  assign m0_hrd   = m1_gnt;
  assign m1_hrd   = m0_gnt;
  assign m0_ready = completion && !owner;
  assign m1_ready = completion && owner;
  assign m0_err   = timeout && !owner;
  assign m1_err   = timeout && owner;
  assign m0_spo   = s_spo;
  assign m1_spo   = s_spo;

  assign burst_hit   = completion && (burst_q == BW'(BURST_MAX - 1));
  assign release_bus = owning &&
                       ((!own_req && !busy_q && !(own_we || own_rd)) || burst_hit);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    busy_d  = busy_q;
    burst_d = burst_q;

    if (fwd) begin
      busy_d = 1'b1;
    end else if (completion) begin
      busy_d  = 1'b0;
      burst_d = burst_q + BW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          state_d = last_q ? StOwn0 : StOwn1;
        end else if (m0_req) begin
          state_d = StOwn0;
        end else if (m1_req) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (release_bus) begin
          state_d = StIdle;
          last_d  = owner;
          burst_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      burst_q <= burst_d;
    end
  end

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .start (fwd),
    .done  (ok),
    .expire(expire)
  );

endmodule
